// File: rtl/ddr2_sequencer_ram_dp_arb.sv
// rtl/ddr2_sequencer_ram_dp_arb.sv - dual-port arbitrated byte-enabled scratch RAM for the DDR2 sequencer
//
// Two Avalon-MM slave ports (s1: sequencer CPU data master, s2: calibration/debug
// master) share one single-port memory array through a round-robin arbiter.
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   clken                 global clock enable; low freezes arbiter, pipeline and memory
//   sN_address            word address (ADDR_WIDTH)
//   sN_chipselect         port select
//   sN_read, sN_write     access request; write wins when both are high
//   sN_byteenable         write byte lanes (DATA_WIDTH/8)
//   sN_writedata          write data
//   sN_readdata           read data, holds between valid pulses
//   sN_readdatavalid      one-cycle pulse qualifying sN_readdata
//   sN_waitrequest        request not accepted this cycle (combinational)
//
// Read latency is 1 cycle with OUT_REG=0 and 2 cycles with OUT_REG=1.

module ddr2_sequencer_ram_dp_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,

    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,

    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic req1, req2;
    logic gnt1, gnt2;
    logic last_s1;      // 1 when s1 was the most recent grant; reset gives s1 first turn

    assign req1 = s1_chipselect & (s1_read | s1_write);
    assign req2 = s2_chipselect & (s2_read | s2_write);

    always_comb begin
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (clken) begin
            if (req1 && (!req2 || !last_s1)) begin
                gnt1 = 1'b1;
            end else if (req2) begin
                gnt2 = 1'b1;
            end
        end
    end

    assign s1_waitrequest = req1 & ~gnt1;
    assign s2_waitrequest = req2 & ~gnt2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_s1 <= 1'b0;
        end else if (gnt1) begin
            last_s1 <= 1'b1;
        end else if (gnt2) begin
            last_s1 <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Granted access mux
    // ------------------------------------------------------------------
    logic                  acc_go;
    logic                  acc_port;   // 0 = s1, 1 = s2
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_wr;
    logic                  acc_rd;
    logic [NB-1:0]         acc_be;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  in_range;
    logic [IW-1:0]         mem_idx;

    assign acc_go    = gnt1 | gnt2;
    assign acc_port  = gnt2;
    assign acc_addr  = gnt2 ? s2_address    : s1_address;
    assign acc_wr    = gnt2 ? s2_write      : s1_write;
    assign acc_rd    = gnt2 ? s2_read       : s1_read;
    assign acc_be    = gnt2 ? s2_byteenable : s1_byteenable;
    assign acc_wdata = gnt2 ? s2_writedata  : s1_writedata;

    assign in_range  = ({1'b0, acc_addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign mem_idx   = acc_addr[IW-1:0];

    // ------------------------------------------------------------------
    // Memory array (contents survive reset)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_go;

    always_ff @(posedge clk) begin
        if (acc_go && acc_wr && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_be[b]) begin
                    mem[mem_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Out-of-range reads still complete, returning zeros.
    assign rd_data = in_range ? mem[mem_idx] : '0;
    // A combined read+write request is treated as a write only.
    assign rd_go   = acc_go & acc_rd & ~acc_wr;

    // ------------------------------------------------------------------
    // Optional extra pipeline stage
    // ------------------------------------------------------------------
    logic                  fin_valid;
    logic                  fin_port;
    logic [DATA_WIDTH-1:0] fin_data;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  p_valid;
            logic                  p_port;
            logic [DATA_WIDTH-1:0] p_data;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    p_valid <= 1'b0;
                    p_port  <= 1'b0;
                    p_data  <= '0;
                end else if (clken) begin
                    p_valid <= rd_go;
                    p_port  <= acc_port;
                    p_data  <= rd_data;
                end
            end

            assign fin_valid = p_valid;
            assign fin_port  = p_port;
            assign fin_data  = p_data;
        end else begin : g_no_out_reg
            assign fin_valid = rd_go;
            assign fin_port  = acc_port;
            assign fin_data  = rd_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-port output registers
    // ------------------------------------------------------------------
    logic s1_rdv_q, s2_rdv_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_rdv_q    <= 1'b0;
            s2_rdv_q    <= 1'b0;
            s1_readdata <= '0;
            s2_readdata <= '0;
        end else if (clken) begin
            s1_rdv_q <= fin_valid & ~fin_port;
            s2_rdv_q <= fin_valid &  fin_port;
            if (fin_valid && !fin_port) begin
                s1_readdata <= fin_data;
            end
            if (fin_valid && fin_port) begin
                s2_readdata <= fin_data;
            end
        end
    end

    // A pulse registered just before a stall stays pending in the flop and
    // is shown exactly once, in the first enabled cycle after the stall.
    assign s1_readdatavalid = s1_rdv_q & clken;
    assign s2_readdatavalid = s2_rdv_q & clken;

endmodule

// File: tb/tb_ddr2_sequencer_ram_dp_arb.sv
// tb/tb_ddr2_sequencer_ram_dp_arb.sv - self-checking bench for ddr2_sequencer_ram_dp_arb

module tb_ddr2_sequencer_ram_dp_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clken;
    logic [9:0]  s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write;
    logic        s2_chipselect, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;

    logic [31:0] q0_s1_readdata, q0_s2_readdata, q1_s1_readdata, q1_s2_readdata;
    logic        q0_s1_rdv, q0_s2_rdv, q1_s1_rdv, q1_s2_rdv;
    logic        q0_s1_wait, q0_s2_wait, q1_s1_wait, q1_s2_wait;

    always #5 clk = ~clk;

    ddr2_sequencer_ram_dp_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .OUT_REG(0)) u0 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(q0_s1_readdata), .s1_readdatavalid(q0_s1_rdv), .s1_waitrequest(q0_s1_wait),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(q0_s2_readdata), .s2_readdatavalid(q0_s2_rdv), .s2_waitrequest(q0_s2_wait)
    );

    ddr2_sequencer_ram_dp_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .OUT_REG(1)) u1 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(q1_s1_readdata), .s1_readdatavalid(q1_s1_rdv), .s1_waitrequest(q1_s1_wait),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(q1_s2_readdata), .s2_readdatavalid(q1_s2_rdv), .s2_waitrequest(q1_s2_wait)
    );

    // op: 0 idle, 1 read, 2 write. ew/ev bit0 = s1, bit1 = s2.
    // ev0/ed0: OUT_REG=0 instance; ev1/ed1: OUT_REG=1 instance.
    typedef struct {
        logic [1:0]  op1;
        logic [9:0]  a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic [1:0]  op2;
        logic [9:0]  a2;
        logic [3:0]  be2;
        logic [31:0] d2;
        logic [1:0]  ew;
        logic [1:0]  ev0;
        logic [31:0] ed0;
        logic [1:0]  ev1;
        logic [31:0] ed1;
    } vec_t;

    vec_t vec [0:21];

    int nchk = 0;
    int nerr = 0;
    logic [31:0] x0_1, x0_2, x1_1, x1_2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic [1:0] op, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        s1_chipselect = (op != 2'd0);
        s1_read       = (op == 2'd1);
        s1_write      = (op == 2'd2);
        s1_address    = a;
        s1_byteenable = be;
        s1_writedata  = d;
    endtask

    task automatic drive2(input logic [1:0] op, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        s2_chipselect = (op != 2'd0);
        s2_read       = (op == 2'd1);
        s2_write      = (op == 2'd2);
        s2_address    = a;
        s2_byteenable = be;
        s2_writedata  = d;
    endtask

    task automatic chk_valid(input string tag, input logic [1:0] ev0, input logic [1:0] ev1);
        chk({tag, " u0 s1 valid"}, {31'd0, q0_s1_rdv}, {31'd0, ev0[0]});
        chk({tag, " u0 s2 valid"}, {31'd0, q0_s2_rdv}, {31'd0, ev0[1]});
        chk({tag, " u1 s1 valid"}, {31'd0, q1_s1_rdv}, {31'd0, ev1[0]});
        chk({tag, " u1 s2 valid"}, {31'd0, q1_s2_rdv}, {31'd0, ev1[1]});
    endtask

    task automatic chk_data(input string tag);
        chk({tag, " u0 s1 data"}, q0_s1_readdata, x0_1);
        chk({tag, " u0 s2 data"}, q0_s2_readdata, x0_2);
        chk({tag, " u1 s1 data"}, q1_s1_readdata, x1_1);
        chk({tag, " u1 s2 data"}, q1_s2_readdata, x1_2);
    endtask

    initial begin
        vec[0]  = '{2'd2, 10'd5,    4'hF, 32'hDEADBEEF, 2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd0, 32'h0};
        vec[1]  = '{2'd1, 10'd5,    4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd0, 32'h0};
        vec[2]  = '{2'd0, 10'd0,    4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd1, 32'hDEADBEEF, 2'd0, 32'h0};
        vec[3]  = '{2'd2, 10'd7,    4'hF, 32'hFFFFFFFF, 2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd1, 32'hDEADBEEF};
        vec[4]  = '{2'd2, 10'd7,    4'h5, 32'h00000000, 2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd0, 32'h0};
        vec[5]  = '{2'd1, 10'd7,    4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd0, 32'h0};
        vec[6]  = '{2'd0, 10'd0,    4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd1, 32'hFF00FF00, 2'd0, 32'h0};
        vec[7]  = '{2'd0, 10'd0,    4'h0, 32'h0,        2'd2, 10'd3, 4'hF, 32'h12345678, 2'd0, 2'd0, 32'h0, 2'd1, 32'hFF00FF00};
        vec[8]  = '{2'd1, 10'd3,    4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd0, 32'h0};
        vec[9]  = '{2'd0, 10'd0,    4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd1, 32'h12345678, 2'd0, 32'h0};
        vec[10] = '{2'd2, 10'd1010, 4'hF, 32'hAAAA5555, 2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd1, 32'h12345678};
        vec[11] = '{2'd1, 10'd1010, 4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd0, 32'h0};
        vec[12] = '{2'd0, 10'd0,    4'h0, 32'h0,        2'd1, 10'd3, 4'h0, 32'h0, 2'd0, 2'd1, 32'h00000000, 2'd0, 32'h0};
        vec[13] = '{2'd1, 10'd5,    4'h0, 32'h0,        2'd1, 10'd7, 4'h0, 32'h0, 2'd2, 2'd2, 32'h12345678, 2'd1, 32'h00000000};
        vec[14] = '{2'd1, 10'd5,    4'h0, 32'h0,        2'd1, 10'd7, 4'h0, 32'h0, 2'd1, 2'd1, 32'hDEADBEEF, 2'd2, 32'h12345678};
        vec[15] = '{2'd1, 10'd5,    4'h0, 32'h0,        2'd1, 10'd7, 4'h0, 32'h0, 2'd2, 2'd2, 32'hFF00FF00, 2'd1, 32'hDEADBEEF};
        vec[16] = '{2'd1, 10'd5,    4'h0, 32'h0,        2'd1, 10'd7, 4'h0, 32'h0, 2'd1, 2'd1, 32'hDEADBEEF, 2'd2, 32'hFF00FF00};
        vec[17] = '{2'd1, 10'd5,    4'h0, 32'h0,        2'd1, 10'd7, 4'h0, 32'h0, 2'd2, 2'd2, 32'hFF00FF00, 2'd1, 32'hDEADBEEF};
        vec[18] = '{2'd1, 10'd5,    4'h0, 32'h0,        2'd1, 10'd7, 4'h0, 32'h0, 2'd1, 2'd1, 32'hDEADBEEF, 2'd2, 32'hFF00FF00};
        vec[19] = '{2'd0, 10'd0,    4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd2, 32'hFF00FF00, 2'd1, 32'hDEADBEEF};
        vec[20] = '{2'd0, 10'd0,    4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd2, 32'hFF00FF00};
        vec[21] = '{2'd0, 10'd0,    4'h0, 32'h0,        2'd0, 10'd0, 4'h0, 32'h0, 2'd0, 2'd0, 32'h0, 2'd0, 32'h0};

        // Reset state
        reset_n = 1'b0;
        clken   = 1'b1;
        drive1(2'd0, 10'd0, 4'h0, 32'h0);
        drive2(2'd0, 10'd0, 4'h0, 32'h0);
        x0_1 = '0; x0_2 = '0; x1_1 = '0; x1_2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_valid("reset", 2'd0, 2'd0);
        chk_data("reset");
        chk("reset s1 wait idle", {31'd0, q0_s1_wait}, 32'd0);
        chk("reset s2 wait idle", {31'd0, q0_s2_wait}, 32'd0);
        drive1(2'd1, 10'd0, 4'h0, 32'h0);
        drive2(2'd1, 10'd0, 4'h0, 32'h0);
        #1;
        chk("reset s1 first wait1", {31'd0, q0_s1_wait}, 32'd0);
        chk("reset s1 first wait2", {31'd0, q0_s2_wait}, 32'd1);
        drive1(2'd0, 10'd0, 4'h0, 32'h0);
        drive2(2'd0, 10'd0, 4'h0, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Table-driven main sequence
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            drive1(vec[i].op1, vec[i].a1, vec[i].be1, vec[i].d1);
            drive2(vec[i].op2, vec[i].a2, vec[i].be2, vec[i].d2);
            @(negedge clk);
            chk($sformatf("row%0d u0 wait1", i), {31'd0, q0_s1_wait}, {31'd0, vec[i].ew[0]});
            chk($sformatf("row%0d u0 wait2", i), {31'd0, q0_s2_wait}, {31'd0, vec[i].ew[1]});
            chk($sformatf("row%0d u1 wait1", i), {31'd0, q1_s1_wait}, {31'd0, vec[i].ew[0]});
            chk($sformatf("row%0d u1 wait2", i), {31'd0, q1_s2_wait}, {31'd0, vec[i].ew[1]});
            chk_valid($sformatf("row%0d", i), vec[i].ev0, vec[i].ev1);
            if (vec[i].ev0[0]) x0_1 = vec[i].ed0;
            if (vec[i].ev0[1]) x0_2 = vec[i].ed0;
            if (vec[i].ev1[0]) x1_1 = vec[i].ed1;
            if (vec[i].ev1[1]) x1_2 = vec[i].ed1;
            chk_data($sformatf("row%0d", i));
        end

        // Stall: read granted, then clken low 3 cycles with s1 requesting
        @(posedge clk); #1;
        drive1(2'd1, 10'd5, 4'h0, 32'h0);
        @(negedge clk);
        chk("stall grant wait1", {31'd0, q0_s1_wait}, 32'd0);
        @(posedge clk); #1;
        clken = 1'b0;
        drive1(2'd1, 10'd7, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk($sformatf("stall%0d wait1", k), {31'd0, q0_s1_wait}, 32'd1);
            chk($sformatf("stall%0d u1 wait1", k), {31'd0, q1_s1_wait}, 32'd1);
            chk_valid($sformatf("stall%0d", k), 2'd0, 2'd0);
        end
        @(posedge clk); #1;
        clken = 1'b1;
        drive1(2'd0, 10'd0, 4'h0, 32'h0);
        @(negedge clk);
        chk_valid("release0", 2'd1, 2'd0);
        chk("release0 u0 s1 data", q0_s1_readdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk_valid("release1", 2'd0, 2'd1);
        chk("release1 u1 s1 data", q1_s1_readdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk_valid("release2", 2'd0, 2'd0);

        // Reset with a read in flight
        @(posedge clk); #1;
        drive1(2'd1, 10'd7, 4'h0, 32'h0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        drive1(2'd0, 10'd0, 4'h0, 32'h0);
        x0_1 = '0; x0_2 = '0; x1_1 = '0; x1_2 = '0;
        @(negedge clk);
        chk_valid("inflight rst", 2'd0, 2'd0);
        chk_data("inflight rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_valid($sformatf("post rst%0d", k), 2'd0, 2'd0);
            @(posedge clk); #1;
        end

        // Contents survive reset
        drive1(2'd1, 10'd5, 4'h0, 32'h0);
        @(posedge clk); #1;
        drive1(2'd0, 10'd0, 4'h0, 32'h0);
        @(negedge clk);
        chk_valid("keep0", 2'd1, 2'd0);
        chk("keep0 u0 s1 data", q0_s1_readdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk_valid("keep1", 2'd0, 2'd1);
        chk("keep1 u1 s1 data", q1_s1_readdata, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ddr2_sequencer_ram_dp_arb.md
Name: ddr2_sequencer_ram_dp_arb

Overview:
Parametrised successor to the sequencer's single-port byte-enabled scratch RAM. It exposes two independent Avalon-MM slave ports, s1 and s2, onto one shared single-port memory array. Conflicts are resolved by a round-robin arbiter with waitrequest. Read latency is 1 or 2 cycles and is signalled with readdatavalid. The block sits between the sequencer CPU data master (s1) and the calibration/debug master (s2).

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, word address width.
DEPTH, 1024, number of implemented words; must be <= 2**ADDR_WIDTH.
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
clken  in  1  global clock enable; 0 freezes arbiter, pipeline and memory
s1_address  in  ADDR_WIDTH  word address
s1_chipselect  in  1  port select
s1_read  in  1  read request
s1_write  in  1  write request
s1_byteenable  in  DATA_WIDTH/8  write byte lanes
s1_writedata  in  DATA_WIDTH  write data
s1_readdata  out  DATA_WIDTH  read data
s1_readdatavalid  out  1  one-cycle pulse qualifying s1_readdata
s1_waitrequest  out  1  request not accepted this cycle
s2_* : identical set of 9 ports for port 2

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (clk, reset_n).
- reqN = sN_chipselect & (sN_read | sN_write). If read and write are both high, the access is a write only; no readdatavalid is produced.
- Grant is evaluated every cycle with clken=1:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not granted most recently wins.
  - Last-grant pointer updates on every grant. Reset value of the pointer gives s1 priority first.
- sN_waitrequest = reqN & ~grantN. It is combinational and is asserted for any request while clken=0. Masters hold their request until waitrequest is low (Avalon rule).
- Write: granted byte lanes are updated at the clock edge and other lanes are preserved. byteenable=0 is a legal no-op write.
- Read:
  - OUT_REG=0: data and sN_readdatavalid are registered one clken-cycle after grant.
  - OUT_REG=1: a second stage adds one further cycle.
  - Valid pulses for exactly one clock and goes only to the issuing port. The other port's readdata is unchanged.
  - sN_readdata holds its last value between pulses.
- Pipelined back-to-back reads are accepted every cycle, at one access per cycle across both ports.
- Ordering: the single array guarantees sequential consistency. A read granted in a cycle after a write sees the written data, including cross-port.
- Address >= DEPTH: write discarded; read returns all zeros with a normal valid pulse.
- clken=0: no grant, pipeline stages and valid outputs hold, and no memory update. A valid pulse pending at the stall is held, not repeated on release; the valid output is gated by clken.
- Reset (async assert):
  - Both readdata go to 0, both readdatavalid to 0, pipeline valid tags are cleared, and the pointer returns to s1-first.
  - Memory contents are NOT cleared.
  - Reads in flight are dropped with no valid pulse after release.
- waitrequest depends only on inputs, grant pointer and clken. It is 0 during reset when there is no request.

Test Plan:
- Single port, OUT_REG=0: s1 writes 0xDEADBEEF to addr 5 (be=0xF), then reads addr 5 -> s1_readdatavalid is high exactly 1 cycle after grant with 0xDEADBEEF; s2_readdatavalid stays 0.
- Byte enables: write 0xFFFFFFFF to addr 7, then write 0x00000000 with be=0x5 -> read returns 0xFF00FF00.
- Contention: s1 and s2 both read continuously for 6 cycles -> grants alternate s1,s2,s1,...; each port sees 3 valid pulses; waitrequest is high on the losing port each cycle.
- Cross-port ordering, OUT_REG=1: s2 writes 0x12345678 to addr 3 in cycle t, s1 reads addr 3 in t+1 -> s1 valid at t+3 with 0x12345678.
- Out of range (DEPTH=1000): write 0xAAAA5555 to addr 1010, then read addr 1010 -> 0x00000000 with a valid pulse.
- Reset and stall:
  - clken low for 3 cycles with s1 requesting -> waitrequest high and no valid pulses.
  - reset_n asserted with a read in flight -> no valid pulse after release.
  - Contents written before reset are still readable afterwards.
